data_mem: RTL
=============

# data_mem

Wishbone-classic data memory slave that sits directly downstream of the memory stage. It consumes that stage's cyc/stb/we, address and store data, holds a word-organised RAM with byte-lane writes, and returns load data with an ack (or err) after a configurable number of wait states. It is the block the memory stage's bus outputs terminate on inside the processing unit.

## Interface
- DWIDTH, 32, data bus width; multiple of 8
- AWIDTH, 12, byte-address width; word index = addr[AWIDTH-1:2]
- DEPTH, 1024, number of DWIDTH words implemented; must be ≤ 2^(AWIDTH-2)
- WAIT_STATES, 1, extra cycles between accept and response; 0..15
- dm_clk  in  1  clock; all state changes on rising edge
- dm_rst  in  1  reset; one clock; reset is asynchronous and active-low
- dm_i_cyc  in  1  bus cycle active
- dm_i_stb  in  1  request strobe
- dm_i_we  in  1  1 = store, 0 = load
- dm_i_addr  in  AWIDTH  byte address; bits [1:0] ignored
- dm_i_data  in  DWIDTH  store data
- dm_i_sel  in  DWIDTH/8  byte-lane enables; bit i → data[8i+7:8i]
- dm_o_data  out  DWIDTH  load data, valid while dm_o_ack=1
- dm_o_ack  out  1  one-cycle successful-completion pulse
- dm_o_err  out  1  one-cycle error pulse (word index ≥ DEPTH)
- dm_o_stall  out  1  1 = request will not be accepted this cycle

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: dm_o_stall=0. When dm_i_cyc & dm_i_stb, latch addr, data, sel, and we, then load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else RESP.
- WAIT: dm_o_stall=1. Counter decrements each cycle; leave for RESP on the edge where the counter is 1.
- WAIT, dm_i_cyc=0 (abort): return to IDLE next edge. No memory write, no ack, no err.
- The access is performed on the edge entering RESP:
  - In range, store: write the lanes with latched sel=1; other lanes keep their value. sel=0 writes nothing but still acks.
  - In range, load: register the full word into dm_o_data; sel is ignored for loads.
  - Out of range: no write; dm_o_data=0; err is raised instead of ack.
- RESP: dm_o_stall=1; dm_o_ack (or dm_o_err) =1 for exactly this cycle. Unconditionally return to IDLE next edge. The master cannot stall the response.
- dm_o_ack and dm_o_err are never both 1.
- dm_i_cyc/stb asserted during WAIT/RESP are ignored (stall=1). The master holds them until accepted in IDLE.
- Reset (asynchronous, dm_rst=0): state IDLE, counter 0, dm_o_ack=0, dm_o_err=0, dm_o_data=0, dm_o_stall=0, latched request cleared. RAM contents are not cleared. A reset asserted mid-transaction discards the pending access; a write not yet committed never lands.

## Timing
- Accept edge = edge E where state is IDLE and cyc&stb=1.
- Commit/response: dm_o_ack high in the cycle after edge E+WAIT_STATES, i.e. WAIT_STATES+1 cycles after E.
- Store is visible to a load accepted at or after the edge leaving RESP.
- Throughput: at most one transaction per WAIT_STATES+2 cycles; the next accept can occur at the edge ending RESP+1 cycle (state IDLE).
- dm_o_data holds its last value outside RESP; consumers sample it only with ack.
- dm_o_stall is a registered function of state only; there is no combinational path from inputs to outputs.

## Structure
- header.vh additions:
  - `DM_IDLE, `DM_WAIT, `DM_RESP state encodings (2 bits)
  - `DM_STATE_WIDTH
- One sub-module, dm_ram:
  - single-port synchronous RAM, DEPTH × DWIDTH, per-byte write enables
  - registered read; no reset on the array
  - it is the only part expected to be replaced by a vendor macro
- data_mem holds the FSM, wait counter, request latches, range check, and ack/err generation.

## Test plan
- WAIT_STATES=1: store 0xDEADBEEF, sel=4'b1111, to addr 0x010; then load 0x010 → ack exactly 2 cycles after each accept; load returns 0xDEADBEEF.
- Byte lanes: after the above, store 0x000000AA with sel=4'b0001 to 0x010, then load → 0xDEADBEAA; a store with sel=4'b0000 leaves the word unchanged, still acks.
- Out of range (DEPTH=1024): load addr 0x1000 with AWIDTH=13 → err pulse one cycle, ack=0, dm_o_data=0; a store there does not alter word 0.
- Abort: WAIT_STATES=3, store 0x12345678 to 0x020, drop cyc one cycle after accept → no ack/err, returns to IDLE, later load of 0x020 returns previous contents.
- Reset mid-op: assert dm_rst=0 asynchronously while in WAIT during a store → outputs zero immediately, stall=0; after release a load of that address returns pre-store data.
- Back-to-back with WAIT_STATES=0: cyc/stb held high for 4 requests → ack pulses every 2 cycles, stall high in every RESP cycle, no request lost or duplicated.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and widths for the data_mem Wishbone data-memory slave.
package data_mem_pkg;

    localparam int unsigned DM_STATE_WIDTH = 2;
    localparam int unsigned DM_CNT_WIDTH   = 4;

    typedef enum logic [DM_STATE_WIDTH-1:0] {
        DM_IDLE = 2'd0,
        DM_WAIT = 2'd1,
        DM_RESP = 2'd2
    } dm_state_e;

    // Word-index range check, done in 32 bits so any index width compares cleanly.
    function automatic logic dm_in_range(input logic [31:0] word_idx, input int unsigned depth);
        return word_idx < depth;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
// The array has no reset; this is the piece a vendor macro would replace.
module dm_ram #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RAW    = 10
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [DWIDTH/8-1:0]   be_i,
    input  logic [RAW-1:0]        addr_i,
    input  logic [DWIDTH-1:0]     wdata_i,
    output logic [DWIDTH-1:0]     rdata_o
);

    localparam int unsigned NB = DWIDTH / 8;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q;

    // Loads capture the whole word; stores touch only enabled lanes.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < NB; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Wishbone-classic data memory slave: request latch, wait-state FSM,
// range check and ack/err generation around a dm_ram array.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 12,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  dm_clk,
    input  logic                  dm_rst,
    input  logic                  dm_i_cyc,
    input  logic                  dm_i_stb,
    input  logic                  dm_i_we,
    input  logic [AWIDTH-1:0]     dm_i_addr,
    input  logic [DWIDTH-1:0]     dm_i_data,
    input  logic [DWIDTH/8-1:0]   dm_i_sel,
    output logic [DWIDTH-1:0]     dm_o_data,
    output logic                  dm_o_ack,
    output logic                  dm_o_err,
    output logic                  dm_o_stall
);

    localparam int unsigned NB  = DWIDTH / 8;
    localparam int unsigned IW  = AWIDTH - 2;
    localparam int unsigned RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dm_state_e                state_q, state_d;
    logic [DM_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]            word_q;
    logic [DWIDTH-1:0]        wdata_q;
    logic [NB-1:0]            sel_q;
    logic                     we_q;
    logic                     ack_q, err_q, stall_q;
    logic [DWIDTH-1:0]        hold_q;

    logic                     accept_c, go_resp_c, in_range_c, ram_en_c;
    logic [IW-1:0]            word_c;
    logic [DWIDTH-1:0]        wdata_c;
    logic [NB-1:0]            sel_c;
    logic                     we_c;
    logic [DWIDTH-1:0]        ram_rdata;
    logic [1:0]               unused_addr_lsbs;

    assign unused_addr_lsbs = dm_i_addr[1:0];

    // With zero wait states the access commits on the accept edge, so use live inputs in IDLE.
    always_comb begin
        word_c  = word_q;
        wdata_c = wdata_q;
        sel_c   = sel_q;
        we_c    = we_q;
        if (state_q == DM_IDLE) begin
            word_c  = dm_i_addr[AWIDTH-1:2];
            wdata_c = dm_i_data;
            sel_c   = dm_i_sel;
            we_c    = dm_i_we;
        end
    end

    assign in_range_c = dm_in_range(32'(word_c), DEPTH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept_c  = 1'b0;
        go_resp_c = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (dm_i_cyc && dm_i_stb) begin
                    accept_c = 1'b1;
                    cnt_d    = DM_CNT_WIDTH'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = DM_RESP;
                        go_resp_c = 1'b1;
                    end else begin
                        state_d = DM_WAIT;
                    end
                end
            end
            DM_WAIT: begin
                if (!dm_i_cyc) begin
                    state_d = DM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DM_CNT_WIDTH'(1)) begin
                    state_d   = DM_RESP;
                    go_resp_c = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q - DM_CNT_WIDTH'(1);
                end
            end
            DM_RESP: state_d = DM_IDLE;
            default: state_d = DM_IDLE;
        endcase
    end

    // Gate with reset so a write can never land while reset is held.
    assign ram_en_c = go_resp_c & in_range_c & dm_rst;

    always_ff @(posedge dm_clk or negedge dm_rst) begin
        if (!dm_rst) begin
            state_q <= DM_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= go_resp_c & in_range_c;
            err_q   <= go_resp_c & ~in_range_c;
            stall_q <= (state_d != DM_IDLE);
            if (accept_c) begin
                word_q  <= dm_i_addr[AWIDTH-1:2];
                wdata_q <= dm_i_data;
                sel_q   <= dm_i_sel;
                we_q    <= dm_i_we;
            end
            if (go_resp_c && !in_range_c) begin
                hold_q <= '0;
            end else if (state_q == DM_RESP && ack_q && !we_q) begin
                hold_q <= ram_rdata;
            end
        end
    end

    dm_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .RAW    (RAW)
    ) u_ram (
        .clk_i   (dm_clk),
        .en_i    (ram_en_c),
        .we_i    (we_c),
        .be_i    (sel_c),
        .addr_i  (word_c[RAW-1:0]),
        .wdata_i (wdata_c),
        .rdata_o (ram_rdata)
    );

    // Load data appears straight from the RAM read register during RESP, then is held.
    assign dm_o_data  = (state_q == DM_RESP && ack_q && !we_q) ? ram_rdata : hold_q;
    assign dm_o_ack   = ack_q;
    assign dm_o_err   = err_q;
    assign dm_o_stall = stall_q;

endmodule
